// File: rtl/ahbl_apb3_bridge.sv
// AHB-Lite slave to APB3 master bridge.
// Each captured AHB-Lite NONSEQ/SEQ transfer becomes exactly one APB3 SETUP/ACCESS transfer.
// Every AHB and APB control output is a register updated together with the state, so no AHB
// input reaches HREADYOUT, HRESP, PSEL or PENABLE combinationally.
module ahbl_apb3_bridge #(
   parameter int unsigned ADDR_W  = 20,
   // Max ACCESS cycles spent waiting for PREADY; 0 waits forever, 1..255 are legal
   parameter int unsigned TIMEOUT = 0
) (
   input  logic              HCLK,
   input  logic              HRESETN,
   // AHB-Lite slave side
   input  logic              HSEL,
   input  logic [31:0]       HADDR,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [1:0]        HTRANS,
   input  logic [31:0]       HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic              HRESP,
   output logic [31:0]       HRDATA,
   // APB3 master side
   output logic              PSEL,
   output logic              PENABLE,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PWRITE,
   output logic [31:0]       PWDATA,
   input  logic [31:0]       PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   typedef enum logic [2:0] {
      StIdle,
      StLatch,
      StSetup,
      StAccess,
      StDone,
      StErr1,
      StErr2
   } state_e;

   // Counter value on the last ACCESS cycle allowed before the transfer is abandoned
   localparam logic [7:0] TimeoutLast = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

   state_e     state_q;
   logic [2:0] hsize_q;
   logic [7:0] to_cnt_q;

   logic capture;
   logic can_capture;
   logic timeout_hit;
   logic unused_bits;

   assign capture     = HSEL & HTRANS[1] & HREADY;
   assign can_capture = (state_q == StIdle) || (state_q == StDone) || (state_q == StErr2);
   assign timeout_hit = (TIMEOUT != 0) && (to_cnt_q == TimeoutLast) && !PREADY;

   // HSIZE is held for visibility only; the upper address bits and HTRANS[0] are not needed
   assign unused_bits = ^{HADDR, HTRANS[0], hsize_q};

   // Transfer FSM with all bus-facing outputs registered alongside the state
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         state_q   <= StIdle;
         hsize_q   <= 3'd0;
         to_cnt_q  <= 8'd0;
         HREADYOUT <= 1'b1;
         HRESP     <= 1'b0;
         HRDATA    <= 32'd0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PADDR     <= '0;
         PWRITE    <= 1'b0;
         PWDATA    <= 32'd0;
      end else begin
         case (state_q)
            StIdle, StDone, StErr2: begin
               PSEL    <= 1'b0;
               PENABLE <= 1'b0;
               HRESP   <= 1'b0;
               if (capture && can_capture) begin
                  state_q   <= StLatch;
                  PADDR     <= HADDR[ADDR_W-1:0];
                  PWRITE    <= HWRITE;
                  hsize_q   <= HSIZE;
                  HREADYOUT <= 1'b0;
               end else begin
                  // IDLE/BUSY or unselected cycles get a zero-wait OKAY
                  state_q   <= StIdle;
                  HREADYOUT <= 1'b1;
               end
            end

            StLatch: begin
               // HWDATA is valid in the first data-phase cycle
               if (PWRITE) begin
                  PWDATA <= HWDATA;
               end
               state_q   <= StSetup;
               PSEL      <= 1'b1;
               PENABLE   <= 1'b0;
               HREADYOUT <= 1'b0;
            end

            StSetup: begin
               state_q  <= StAccess;
               PENABLE  <= 1'b1;
               to_cnt_q <= 8'd0;
            end

            StAccess: begin
               if (PREADY) begin
                  if (!PWRITE) begin
                     HRDATA <= PRDATA;
                  end
                  PSEL    <= 1'b0;
                  PENABLE <= 1'b0;
                  if (PSLVERR) begin
                     state_q   <= StErr1;
                     HREADYOUT <= 1'b0;
                     HRESP     <= 1'b1;
                  end else begin
                     state_q   <= StDone;
                     HREADYOUT <= 1'b1;
                     HRESP     <= 1'b0;
                  end
               end else begin
                  if (to_cnt_q != 8'hFF) begin
                     to_cnt_q <= to_cnt_q + 8'd1;
                  end
                  if (timeout_hit) begin
                     // Abandon the APB transfer and report it as an AHB ERROR
                     state_q   <= StErr1;
                     PSEL      <= 1'b0;
                     PENABLE   <= 1'b0;
                     HREADYOUT <= 1'b0;
                     HRESP     <= 1'b1;
                  end
               end
            end

            StErr1: begin
               // Second cycle of the two-cycle ERROR response
               state_q   <= StErr2;
               PSEL      <= 1'b0;
               PENABLE   <= 1'b0;
               HREADYOUT <= 1'b1;
               HRESP     <= 1'b1;
            end

            default: begin
               state_q   <= StIdle;
               PSEL      <= 1'b0;
               PENABLE   <= 1'b0;
               HREADYOUT <= 1'b1;
               HRESP     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahbl_apb3_bridge.sv
// Self-checking bench for ahbl_apb3_bridge: a pipelined AHB-Lite master, a scripted APB
// slave and scoreboard queues filled when each transfer is accepted.
module tb_ahbl_apb3_bridge;

   localparam int unsigned TbAddrW   = 20;
   localparam int unsigned TbTimeout = 4;

   logic               HCLK;
   logic               HRESETN;
   logic               HSEL;
   logic [31:0]        HADDR;
   logic               HWRITE;
   logic [2:0]         HSIZE;
   logic [1:0]         HTRANS;
   logic [31:0]        HWDATA;
   logic               HREADY;
   logic               HREADYOUT;
   logic               HRESP;
   logic [31:0]        HRDATA;
   logic               PSEL;
   logic               PENABLE;
   logic [TbAddrW-1:0] PADDR;
   logic               PWRITE;
   logic [31:0]        PWDATA;
   logic [31:0]        PRDATA = 32'd0;
   logic               PREADY = 1'b0;
   logic               PSLVERR = 1'b0;

   // Single slave on the bus: the bus-level ready is this slave's ready
   assign HREADY = HREADYOUT;

   ahbl_apb3_bridge #(
      .ADDR_W  (TbAddrW),
      .TIMEOUT (TbTimeout)
   ) dut (
      .HCLK      (HCLK),
      .HRESETN   (HRESETN),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HTRANS    (HTRANS),
      .HWDATA    (HWDATA),
      .HREADY    (HREADY),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .HRDATA    (HRDATA),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PADDR     (PADDR),
      .PWRITE    (PWRITE),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      int unsigned wait_n;
      logic        err;
      logic        hang;
      logic [31:0] rdata;
   } xfer_t;

   typedef struct {
      logic [TbAddrW-1:0] paddr;
      logic               pwrite;
      logic [31:0]        pwdata;
      int unsigned        wait_n;
      logic               err;
      logic               hang;
      logic [31:0]        prdata;
   } apb_exp_t;

   typedef struct {
      logic        write;
      int          low;
      logic        resp;
      logic [31:0] rdata;
   } ahb_exp_t;

   xfer_t    stim_q[$];
   apb_exp_t apb_q[$];
   ahb_exp_t ahb_q[$];

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [31:0] hrdata_model = 32'd0;
   logic [31:0] wdata_model = 32'd0;

   function automatic xfer_t mk(input logic [31:0] addr, input logic write,
                                input logic [31:0] wdata, input int unsigned wait_n,
                                input logic err, input logic hang, input logic [31:0] rdata);
      xfer_t x;
      x.addr = addr; x.write = write; x.wdata = wdata; x.wait_n = wait_n;
      x.err = err; x.hang = hang; x.rdata = rdata;
      return x;
   endfunction

   // Expected APB transfer and AHB response for a transfer accepted now
   function automatic void push_expect(input xfer_t x);
      apb_exp_t a;
      ahb_exp_t h;
      if (x.write) wdata_model = x.wdata;
      a.paddr = x.addr[TbAddrW-1:0];
      a.pwrite = x.write;
      a.pwdata = wdata_model;
      a.wait_n = x.wait_n;
      a.err = x.err;
      a.hang = x.hang;
      a.prdata = x.rdata;
      apb_q.push_back(a);
      if (!x.write && !x.hang) hrdata_model = x.rdata;
      h.write = x.write;
      h.resp = x.err | x.hang;
      h.rdata = hrdata_model;
      // LATCH + SETUP + ACCESS cycles (+ ERR1 on error)
      if (x.hang) h.low = 2 + int'(TbTimeout) + 1;
      else        h.low = 2 + int'(x.wait_n) + 1 + (x.err ? 1 : 0);
      ahb_q.push_back(h);
   endfunction

   task automatic drive_addr(input xfer_t x);
      HSEL = 1'b1;
      HTRANS = 2'b10;
      HADDR = x.addr;
      HWRITE = x.write;
      HSIZE = 3'b010;
   endtask

   // Scripted APB slave: checks each SETUP against the scoreboard, then answers ACCESS
   apb_exp_t    slv;
   logic        slv_active = 1'b0;
   int unsigned slv_k = 0;
   logic        slv_rdy;
   always @(negedge HCLK) begin
      if (HRESETN && PSEL && !PENABLE) begin
         if (apb_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL apb_unexpected: got SETUP at PADDR=%h, required no transfer", PADDR);
            slv_active = 1'b0;
         end else begin
            slv = apb_q.pop_front();
            slv_active = 1'b1;
            n_cmp++;
            if (PADDR !== slv.paddr) begin
               n_fail++; $display("FAIL apb_paddr: got %h, required %h", PADDR, slv.paddr);
            end
            n_cmp++;
            if (PWRITE !== slv.pwrite) begin
               n_fail++; $display("FAIL apb_pwrite: got %b, required %b", PWRITE, slv.pwrite);
            end
            n_cmp++;
            if (PWDATA !== slv.pwdata) begin
               n_fail++; $display("FAIL apb_pwdata: got %h, required %h", PWDATA, slv.pwdata);
            end
         end
         slv_k = 0;
         PREADY = 1'b0;
         PSLVERR = 1'b0;
      end else if (HRESETN && PSEL && PENABLE && slv_active) begin
         slv_rdy = !slv.hang && (slv_k >= slv.wait_n);
         PREADY = slv_rdy;
         PSLVERR = slv_rdy & slv.err;
         PRDATA = slv_rdy ? slv.prdata : (32'hBAD0_0000 | 32'(slv_k));
         slv_k++;
      end else begin
         PREADY = 1'b0;
         PSLVERR = 1'b0;
      end
   end

   // Pipelined AHB-Lite master: drains stim_q, checks each data phase on completion
   task automatic run_master();
      xfer_t    nxt;
      ahb_exp_t e;
      logic     have_cur;
      logic     have_nxt;
      int       low;
      int       resp_low;
      int       guard;
      have_cur = 1'b0; have_nxt = 1'b0; low = 0; resp_low = 0; guard = 0;
      if (stim_q.size() != 0) begin
         nxt = stim_q.pop_front(); have_nxt = 1'b1; drive_addr(nxt);
      end
      while ((have_cur || have_nxt) && guard < 500) begin
         guard++;
         @(negedge HCLK);
         if (HREADYOUT) begin
            if (have_cur) begin
               e = ahb_q.pop_front();
               n_cmp++;
               if (low != e.low) begin
                  n_fail++; $display("FAIL wait_cycles: got %0d, required %0d", low, e.low);
               end
               n_cmp++;
               if (HRESP !== e.resp) begin
                  n_fail++; $display("FAIL hresp_final: got %b, required %b", HRESP, e.resp);
               end
               n_cmp++;
               if (resp_low != (e.resp ? 1 : 0)) begin
                  n_fail++;
                  $display("FAIL hresp_first: got %0d error wait cycles, required %0d",
                           resp_low, (e.resp ? 1 : 0));
               end
               if (!e.write) begin
                  n_cmp++;
                  if (HRDATA !== e.rdata) begin
                     n_fail++; $display("FAIL hrdata: got %h, required %h", HRDATA, e.rdata);
                  end
               end
            end
            @(posedge HCLK); #1;
            have_cur = have_nxt; low = 0; resp_low = 0;
            if (have_nxt) begin
               push_expect(nxt);
               HWDATA = nxt.write ? nxt.wdata : 32'hDEAD_BEEF;
            end
            if (stim_q.size() != 0) begin
               nxt = stim_q.pop_front(); have_nxt = 1'b1; drive_addr(nxt);
            end else begin
               have_nxt = 1'b0; HSEL = 1'b0; HTRANS = 2'b00;
            end
         end else begin
            low++;
            if (HRESP) begin
               resp_low++;
               n_cmp++;
               if (PSEL !== 1'b0 || PENABLE !== 1'b0) begin
                  n_fail++;
                  $display("FAIL err1_psel: got PSEL=%b PENABLE=%b, required 0 0", PSEL, PENABLE);
               end
            end
            @(posedge HCLK); #1;
         end
      end
      if (guard >= 500) begin
         n_cmp++; n_fail++;
         $display("FAIL master_timeout: got no completion in 500 cycles, required completion");
      end
   endtask

   task automatic test_reset();
      HRESETN = 1'b0; HSEL = 1'b0; HADDR = 32'd0; HWRITE = 1'b0; HSIZE = 3'd0;
      HTRANS = 2'b00; HWDATA = 32'd0;
      #12;
      n_cmp++;
      if ({HREADYOUT, HRESP, PSEL, PENABLE, PWRITE} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b, required 10000",
                  {HREADYOUT, HRESP, PSEL, PENABLE, PWRITE});
      end
      n_cmp++;
      if ({HRDATA, PWDATA, PADDR} !== {64'd0, 20'd0}) begin
         n_fail++;
         $display("FAIL reset_data: got HRDATA=%h PWDATA=%h PADDR=%h, required zeros",
                  HRDATA, PWDATA, PADDR);
      end
      @(negedge HCLK); HRESETN = 1'b1;
      @(posedge HCLK); #1;
   endtask

   task automatic test_no_capture();
      logic [2:0] pats[3];
      pats[0] = 3'b100;   // selected, IDLE
      pats[1] = 3'b101;   // selected, BUSY
      pats[2] = 3'b010;   // NONSEQ but not selected
      for (int i = 0; i < 3; i++) begin
         {HSEL, HTRANS} = pats[i];
         HADDR = 32'h0000_0100; HWRITE = 1'b1;
         @(posedge HCLK); #1;
         @(negedge HCLK);
         n_cmp++;
         if ({HREADYOUT, HRESP, PSEL} !== 3'b100) begin
            n_fail++;
            $display("FAIL no_capture_%0d: got %b, required 100", i, {HREADYOUT, HRESP, PSEL});
         end
      end
      HSEL = 1'b0; HTRANS = 2'b00;
      @(posedge HCLK); #1;
   endtask

   task automatic test_write();
      stim_q.push_back(mk(32'h0000_0010, 1'b1, 32'hA5A5_0001, 0, 1'b0, 1'b0, 32'd0));
      run_master();
      @(negedge HCLK);
      n_cmp++;
      if ({PADDR, PWRITE, PWDATA} !== {20'h00010, 1'b1, 32'hA5A5_0001}) begin
         n_fail++;
         $display("FAIL apb_hold: got PADDR=%h PWRITE=%b PWDATA=%h, required 00010 1 a5a50001",
                  PADDR, PWRITE, PWDATA);
      end
      @(posedge HCLK); #1;
   endtask

   task automatic test_read_wait();
      stim_q.push_back(mk(32'h0000_0014, 1'b0, 32'd0, 3, 1'b0, 1'b0, 32'h1234_5678));
      run_master();
   endtask

   task automatic test_slverr();
      stim_q.push_back(mk(32'h0000_0018, 1'b0, 32'd0, 0, 1'b1, 1'b0, 32'hCAFE_0003));
      run_master();
   endtask

   task automatic test_timeout();
      stim_q.push_back(mk(32'h0000_001C, 1'b0, 32'd0, 0, 1'b0, 1'b1, 32'h7777_7777));
      run_master();
   endtask

   task automatic test_back_to_back();
      stim_q.push_back(mk(32'h0000_0020, 1'b1, 32'h1111_2222, 0, 1'b0, 1'b0, 32'd0));
      stim_q.push_back(mk(32'h0000_0024, 1'b0, 32'd0, 0, 1'b0, 1'b0, 32'h3333_4444));
      stim_q.push_back(mk(32'h1234_5028, 1'b1, 32'h9999_0000, 0, 1'b1, 1'b0, 32'd0));
      stim_q.push_back(mk(32'h0000_002C, 1'b0, 32'd0, 1, 1'b0, 1'b0, 32'h5555_6666));
      run_master();
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         stim_q.push_back(mk($urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), $urandom(),
                             $urandom_range(0, 3), ($urandom_range(0, 3) == 0), 1'b0,
                             $urandom()));
      end
      run_master();
   endtask

   task automatic test_reset_mid();
      xfer_t x;
      logic  seen;
      x = mk(32'h0000_0030, 1'b1, 32'h5555_AAAA, 0, 1'b0, 1'b1, 32'd0);
      drive_addr(x);
      @(posedge HCLK); #1;
      push_expect(x);
      HWDATA = x.wdata; HSEL = 1'b0; HTRANS = 2'b00;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge HCLK);
         if (PSEL === 1'b1 && PENABLE === 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (!seen) begin
         n_fail++; $display("FAIL reach_access: got no ACCESS in 20 cycles, required ACCESS");
      end
      #2 HRESETN = 1'b0;
      #1;
      n_cmp++;
      if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b0010) begin
         n_fail++;
         $display("FAIL async_reset: got %b, required 0010", {PSEL, PENABLE, HREADYOUT, HRESP});
      end
      ahb_q.delete(); apb_q.delete();
      hrdata_model = 32'd0; wdata_model = 32'd0;
      @(negedge HCLK); HRESETN = 1'b1;
      @(posedge HCLK); #1;
      stim_q.push_back(mk(32'h0000_0034, 1'b0, 32'd0, 1, 1'b0, 1'b0, 32'h0BAD_F00D));
      run_master();
   endtask

   initial begin
      test_reset();
      test_no_capture();
      test_write();
      test_read_wait();
      test_slverr();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid();
      n_cmp++;
      if (apb_q.size() != 0 || ahb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d apb / %0d ahb left, required 0 / 0",
                  apb_q.size(), ahb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test by 200000, required earlier end");
      $fatal(1, "watchdog expired");
   end

endmodule
